rr_oh_arbiter: RTL and testbench
================================

// Module: rr_oh_arbiter
// PURPOSE
//   Round-robin arbiter sharing one resource among 2**N requesters.
//   Grant is one-hot (bit k = requester k), with its binary index alongside, so downstream logic can use either form.
//   Sits between requester blocks and the shared datapath; owns the fairness pointer and the per-grant hold limit.
// PARAMETERS
//   N         3   index width; number of requesters = 2**N
//   MAX_HOLD  4   max consecutive cycles one grant may last (>=1)
// PORTS
//   clk          in   1       clock, rising edge
//   rst          in   1       asynchronous reset, active-high
//   req          in   2**N    request vector, level-sensitive, bit k = requester k
//   grant        out  2**N    one-hot grant, registered; all-zero when idle
//   grant_idx    out  N       binary index of granted requester; 0 when idle
//   grant_valid  out  1       1 while any grant is active (== |grant)
// BEHAVIOUR
//   - Reset (async, immediate): grant=0, grant_idx=0, grant_valid=0, ptr=0, hold_cnt=0, state=IDLE.
//   - State IDLE: grant=0.
//     - If req != 0 at a posedge, pick the first set bit scanning ptr, ptr+1, ..., wrapping modulo 2**N.
//     - Go to GRANT with grant=one-hot(sel), grant_idx=sel and hold_cnt=0 at that same edge.
//     - Latency is 1 cycle from req sampled to grant visible.
//   - State GRANT:
//     - release = !req[grant_idx] || (hold_cnt == MAX_HOLD-1).
//     - On release: go to IDLE, grant=0, ptr=(grant_idx+1) mod 2**N (wraps 7->0 for N=3), hold_cnt=0.
//     - Otherwise hold the grant and increment hold_cnt.
//   - Every release is followed by exactly one IDLE cycle (grant=0) before the next grant; no back-to-back grants.
//   - Requests from other requesters during GRANT are ignored until IDLE.
//   - Request drop and timeout in the same cycle count as one release; ptr advances once.
//   - req changing while in IDLE: only the value sampled at the posedge matters.
//   - Invariant: grant is zero or exactly one-hot.
//   - Invariant: grant == (1 << grant_idx) whenever grant_valid=1.
//   - hold_cnt width = $clog2(MAX_HOLD)+1; never exceeds MAX_HOLD-1.
//   - Reset asserted mid-grant: outputs clear immediately, without waiting for a clock; ptr returns to 0.
// TESTING (N=3, MAX_HOLD=4, one check per posedge)
//   1. Reset mid-grant (grant=8'h04):
//      -> assert rst between edges; grant=8'h00, grant_idx=0, grant_valid=0 before the next posedge.
//   2. Single request, req=8'b0000_0100 from IDLE, dropped after 2 granted cycles:
//      -> grant=8'h04, idx=2 at the next edge; 2 cycles later grant=0; next arbitration starts from ptr=3.
//   3. req=8'hFF held:
//      -> grants idx 0,1,...,7,0 in order; each lasts 4 cycles, followed by 1 idle cycle (5-cycle period);
//      -> the 7->0 wrap is checked.
//   4. ptr=3 (after a grant to 2), then req=8'b1000_0011:
//      -> grant order idx 7, then 0, then 1 (each released by dropping its req bit).
//   5. Sole requester req=8'h10 held:
//      -> grant 4 cycles, 1 idle cycle, re-grant to idx 4; pattern repeats with no starvation or deadlock.
//   6. req bit dropped on the same edge hold_cnt=3:
//      -> a single release, ptr advances by exactly 1;
//      -> self-check asserts one-hot and grant==(1<<grant_idx) on every cycle.

Source files
------------

// File: rtl/rr_oh_arbiter.sv
// Round-robin arbiter for 2**N requesters.
// Grants are one-hot with a matching binary index. Each grant is limited to
// MAX_HOLD consecutive cycles, and every release is followed by one idle cycle.
module rr_oh_arbiter #(
  parameter int N        = 3,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2**N-1:0]   req,
  output logic [2**N-1:0]   grant,
  output logic [N-1:0]      grant_idx,
  output logic              grant_valid
);

  localparam int NREQ = 2**N;
  localparam int HW   = $clog2(MAX_HOLD) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_n;
  logic [N-1:0]  ptr, ptr_n;
  logic [N-1:0]  idx, idx_n;
  logic [HW-1:0] hold_cnt, hold_n;

  logic [N-1:0]  sel;
  logic          found;
  logic          release_now;

  // Scan requests starting at ptr, wrapping modulo NREQ; the first set bit wins
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      logic [N-1:0] k;
      k = ptr + N'(i);
      if (!found && req[k]) begin
        sel   = k;
        found = 1'b1;
      end
    end
  end

  // The grant ends when its owner drops the request or the hold limit is reached;
  // if both happen in the same cycle, this still counts as a single release
  always_comb begin
    release_now = !req[idx] || (hold_cnt == HW'(MAX_HOLD - 1));
  end

  // State and arbitration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      idx      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      idx      <= idx_n;
      hold_cnt <= hold_n;
    end
  end

  // Next-state logic: grant from IDLE, hold or release while in GRANT
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    idx_n   = idx;
    hold_n  = hold_cnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          idx_n   = sel;
          hold_n  = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_n = IDLE;
          ptr_n   = idx + N'(1);
          idx_n   = '0;
          hold_n  = '0;
        end else begin
          hold_n  = hold_cnt + HW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output decode: all outputs come straight from registered state
  always_comb begin
    grant       = '0;
    grant_valid = (state == GRANT);
    grant_idx   = idx;
    if (state == GRANT) grant[idx] = 1'b1;
  end

endmodule

// File: tb/tb_rr_oh_arbiter.sv
// Directed self-checking bench for rr_oh_arbiter (N=3, MAX_HOLD=4).
module tb_rr_oh_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;

  int checks   = 0;
  int failures = 0;

  rr_oh_arbiter #(.N(3), .MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all three outputs against the expected state: idle, or granted to idx
  task automatic expect_out(input string tag, input logic valid, input logic [2:0] idx);
    logic [7:0] g;
    g = valid ? (8'h01 << idx) : 8'h00;
    check({tag, "_grant"}, 32'(grant), 32'(g));
    check({tag, "_idx"},   32'(grant_idx), valid ? 32'(idx) : 32'd0);
    check({tag, "_valid"}, 32'(grant_valid), 32'(valid));
  endtask

  // Advance to just after the next rising edge and check the output invariants
  task automatic tick();
    @(posedge clk);
    #1;
    check("inv_onehot", 32'(grant & (grant - 8'd1)), 32'd0);
    check("inv_map", 32'(grant), grant_valid ? 32'(8'h01 << grant_idx) : 32'd0);
    check("inv_valid", 32'(grant_valid), 32'(|grant));
  endtask

  initial begin
    rst = 1'b1;
    req = 8'h00;
    #12;
    expect_out("reset", 1'b0, 3'd0);
    rst = 1'b0;
    tick();
    expect_out("idle0", 1'b0, 3'd0);

    // Single request for bit 2, held for 2 granted cycles and then dropped
    req = 8'b0000_0100;
    tick(); expect_out("single_g1", 1'b1, 3'd2);
    tick(); expect_out("single_g2", 1'b1, 3'd2);
    req = 8'h00;
    tick(); expect_out("single_rel", 1'b0, 3'd0);

    // ptr=3, so 7 wins first, then wraps to 0, then 1
    req = 8'b1000_0011;
    tick(); expect_out("ptr3_g7", 1'b1, 3'd7);
    req = 8'b0000_0011;
    tick(); expect_out("ptr3_i1", 1'b0, 3'd0);
    tick(); expect_out("ptr3_g0", 1'b1, 3'd0);
    req = 8'b0000_0010;
    tick(); expect_out("ptr3_i2", 1'b0, 3'd0);
    tick(); expect_out("ptr3_g1", 1'b1, 3'd1);
    req = 8'h00;
    tick(); expect_out("ptr3_i3", 1'b0, 3'd0);

    // ptr=2: grant 5, then drop it on the edge where hold_cnt reaches 3.
    // ptr must land on 6, not 7.
    req = 8'h20;
    tick(); expect_out("drop_h0", 1'b1, 3'd5);
    tick(); expect_out("drop_h1", 1'b1, 3'd5);
    tick(); expect_out("drop_h2", 1'b1, 3'd5);
    tick(); expect_out("drop_h3", 1'b1, 3'd5);
    req = 8'hC0;
    tick(); expect_out("drop_rel", 1'b0, 3'd0);
    tick(); expect_out("drop_next6", 1'b1, 3'd6);
    req = 8'h00;
    tick(); expect_out("drop_idle", 1'b0, 3'd0);

    // Full load from ptr=0: 4 grant cycles and 1 idle cycle per requester, including the 7->0 wrap
    rst = 1'b1;
    #2;
    rst = 1'b0;
    req = 8'hFF;
    for (int c = 0; c <= 40; c++) begin
      tick();
      expect_out("full", (c % 5) < 4, 3'((c / 5) % 8));
    end
    req = 8'h00;
    tick(); expect_out("full_end", 1'b0, 3'd0);

    // Sole requester 4 repeatedly times out and is granted again
    req = 8'h10;
    for (int c = 0; c < 10; c++) begin
      tick();
      expect_out("sole", (c % 5) < 4, 3'd4);
    end
    req = 8'h00;
    tick();
    tick(); expect_out("sole_end", 1'b0, 3'd0);

    // Asynchronous reset during a grant clears the outputs before the next edge; ptr returns to 0
    req = 8'h04;
    tick(); expect_out("mid_g", 1'b1, 3'd2);
    #2;
    rst = 1'b1;
    #1;
    expect_out("mid_rst", 1'b0, 3'd0);
    #1;
    rst = 1'b0;
    req = 8'h82;
    tick(); expect_out("mid_ptr0", 1'b1, 3'd1);
    req = 8'h00;
    tick(); expect_out("mid_end", 1'b0, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
